// File: rtl/ibex_bus_ram_responder.sv
// Bus responder terminating one Ibex port (instr/data/debug) in on-chip RAM.
// Latency: response strobe ReadLatency cycles after accept; reads and writes alike, strictly in order.
// Backpressure: busy_o while clearing or when MaxOutstanding responses are pending; depends on registered state only.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   read_i, write_i        request strobes (both set = SLVERR, no RAM change)
//   addr_i, be_i, wdata_i  byte address (bits [1:0] ignored), byte enables, write data
//   busy_o                 waitrequest: request not accepted this cycle
//   rvalid_o, rdata_o      read response strobe and data (data 0 when no read response)
//   wrespvalid_o           write response strobe
//   resp_o                 00 OKAY, 10 SLVERR, 11 DECODEERROR with a strobe, else 00
module ibex_bus_ram_responder #(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned ReadLatency    = 1,
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          ClearOnReset   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  resp_o,
  output logic        wrespvalid_o
);

  localparam int unsigned AW      = $clog2(MemWords);
  localparam logic [32:0] EndAddr = {1'b0, BaseAddr} + 33'(4 * MemWords);
  localparam logic [2:0]  MaxOut  = 3'(MaxOutstanding);
  localparam logic [AW-1:0] LastIdx = AW'(MemWords - 1);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [AW-1:0]   r_clr_idx;
  logic [AW-1:0]   w_clr_idx_nxt;
  logic [2:0]      r_outstanding;
  logic [31:0]     r_mem [MemWords];

  // Response pipeline: stage 0 is loaded at the accept edge, the last stage drives the outputs.
  logic [ReadLatency-1:0] r_pv;
  logic [ReadLatency-1:0] r_pw;
  logic [1:0]             r_pr [ReadLatency];
  logic [31:0]            r_pd [ReadLatency];

  logic          w_busy;
  logic          w_accept;
  logic          w_both;
  logic          w_in_range;
  logic [31:0]   w_offset;
  logic [AW-1:0] w_idx;
  logic          w_wr_en;
  logic          w_rd_en;
  logic [1:0]    w_resp_code;
  logic [31:0]   w_rdata;
  logic          w_resp_strobe;
  logic          w_unused_offset;

  assign w_busy   = (r_state == CLEAR) | (r_outstanding == MaxOut);
  assign w_accept = (read_i | write_i) & ~w_busy;
  assign w_both   = read_i & write_i;

  // 33-bit compare so a window ending exactly at 4 GiB does not wrap.
  assign w_in_range = ({1'b0, addr_i} >= {1'b0, BaseAddr}) && ({1'b0, addr_i} < EndAddr);
  assign w_offset   = addr_i - BaseAddr;
  assign w_idx      = w_offset[AW+1:2];
  assign w_unused_offset = ^{w_offset[31:AW+2], w_offset[1:0]};

  assign w_wr_en = w_accept & write_i & ~read_i & w_in_range;
  assign w_rd_en = w_accept & read_i & ~write_i & w_in_range;

  assign w_resp_code = w_both      ? RespSlvErr :
                       !w_in_range ? RespDecErr : RespOkay;

  // Synchronous read at the accept edge sees every write accepted at earlier edges.
  assign w_rdata = w_rd_en ? r_mem[w_idx] : 32'h0;

  assign w_resp_strobe = r_pv[ReadLatency-1];

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ClearOnReset ? CLEAR : READY;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  // FSM next state: leave CLEAR right after the last word has been zeroed.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      CLEAR: begin
        w_clr_idx_nxt = r_clr_idx + AW'(1);
        if (r_clr_idx == LastIdx) begin
          w_state_nxt = READY;
        end
      end
      READY: begin
        w_state_nxt = READY;
      end
      default: begin
        w_state_nxt = READY;
      end
    endcase
  end

  // RAM array: no reset, contents are defined only by the clear pass or by writes.
  always_ff @(posedge clk_i) begin
    if (r_state == CLEAR) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Outstanding counter and response pipeline; reset discards everything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
      r_pv          <= '0;
      r_pw          <= '0;
      for (int i = 0; i < ReadLatency; i++) begin
        r_pr[i] <= '0;
        r_pd[i] <= '0;
      end
    end else begin
      case ({w_accept, w_resp_strobe})
        2'b10:   r_outstanding <= r_outstanding + 3'd1;
        2'b01:   r_outstanding <= r_outstanding - 3'd1;
        default: r_outstanding <= r_outstanding;
      endcase

      r_pv[0] <= w_accept;
      r_pw[0] <= write_i;
      r_pr[0] <= w_accept ? w_resp_code : 2'b00;
      r_pd[0] <= w_rdata;
      for (int i = 1; i < ReadLatency; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pw[i] <= r_pw[i-1];
        r_pr[i] <= r_pr[i-1];
        r_pd[i] <= r_pd[i-1];
      end
    end
  end

  assign busy_o       = w_busy;
  assign rvalid_o     = r_pv[ReadLatency-1] & ~r_pw[ReadLatency-1];
  assign wrespvalid_o = r_pv[ReadLatency-1] &  r_pw[ReadLatency-1];
  assign rdata_o      = rvalid_o ? r_pd[ReadLatency-1] : 32'h0;
  assign resp_o       = r_pv[ReadLatency-1] ? r_pr[ReadLatency-1] : 2'b00;

endmodule

// File: tb/tb_ibex_bus_ram_responder.sv
// Directed self-checking bench for ibex_bus_ram_responder (MemWords=16, ReadLatency=2, MaxOutstanding=2).
// Responses are captured by a negedge monitor with their cycle stamp and checked against hand-computed values.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_ibex_bus_ram_responder;

  localparam int RL = 2;
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] SLV = 2'b10;
  localparam logic [1:0] DEC = 2'b11;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        read_i = 1'b0;
  logic        write_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [3:0]  be_i = '0;
  logic [31:0] wdata_i = '0;
  logic        busy_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic [1:0]  resp_o;
  logic        wrespvalid_o;

  typedef struct {
    int          c;
    bit          w;
    bit [1:0]    r;
    bit [31:0]   d;
  } rsp_t;

  rsp_t rq[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  ibex_bus_ram_responder #(
    .MemWords       (16),
    .BaseAddr       (32'h0000_0000),
    .ReadLatency    (RL),
    .MaxOutstanding (2),
    .ClearOnReset   (1'b1)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .read_i       (read_i),
    .write_i      (write_i),
    .addr_i       (addr_i),
    .be_i         (be_i),
    .wdata_i      (wdata_i),
    .busy_o       (busy_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .resp_o       (resp_o),
    .wrespvalid_o (wrespvalid_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture every response strobe; idle cycles must show zero data/resp.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (rvalid_o || wrespvalid_o) begin
        check_eq("one_strobe", {63'b0, rvalid_o & wrespvalid_o}, 64'd0);
        rq.push_back('{cyc, wrespvalid_o, resp_o, rdata_o});
      end else begin
        check_eq("idle_zero", {30'b0, resp_o, rdata_o}, 64'd0);
      end
    end
  end

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd, output int acc);
    int n;
    @(posedge clk_i); #1;
    read_i = rd; write_i = wr; addr_i = a; be_i = be; wdata_i = wd;
    n = 0;
    @(negedge clk_i);
    while (busy_o && n < 50) begin
      n++;
      @(negedge clk_i);
    end
    check_eq("req_accepted", {63'b0, busy_o}, 64'd0);
    @(posedge clk_i); #1;
    acc = cyc;
    read_i = 1'b0; write_i = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input bit w, input bit [1:0] rc,
                             input bit [31:0] d, input int c);
    int   n;
    rsp_t r;
    n = 0;
    while (rq.size() == 0 && n < 20) begin
      @(negedge clk_i); #1;
      n++;
    end
    check_eq({tag, "_seen"}, 64'(rq.size() != 0), 64'd1);
    if (rq.size() != 0) begin
      r = rq.pop_front();
      check_eq({tag, "_kind"}, {61'b0, r.w, r.r}, {61'b0, w, rc});
      check_eq({tag, "_data"}, {32'b0, r.d}, {32'b0, d});
      check_eq({tag, "_cyc"}, 64'(r.c), 64'(c));
    end
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [3:0] be,
                    input logic [31:0] wd, input bit [1:0] rc);
    int acc;
    do_req(1'b0, 1'b1, a, be, wd, acc);
    expect_resp(tag, 1'b1, rc, 32'h0, acc + RL - 1);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input bit [1:0] rc,
                    input logic [31:0] exp);
    int acc;
    do_req(1'b1, 1'b0, a, 4'h0, 32'h0, acc);
    expect_resp(tag, 1'b0, rc, exp, acc + RL - 1);
  endtask

  // Release reset on a falling edge and count rising edges that see busy_o high.
  task automatic release_and_count(input string tag);
    int n;
    n = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    while (busy_o && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    check_eq(tag, 64'(n), 64'd16);
  endtask

  int a0, a1;
  int k, edges, mout;
  bit acc_b, st_b;
  int acyc[6];
  logic [31:0] tp_exp[6];

  initial begin
    // Reset state.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_busy",   {63'b0, busy_o}, 64'd1);
    check_eq("rst_rvalid", {63'b0, rvalid_o}, 64'd0);
    check_eq("rst_wresp",  {63'b0, wrespvalid_o}, 64'd0);
    check_eq("rst_rdata",  {32'b0, rdata_o}, 64'd0);
    check_eq("rst_resp",   {62'b0, resp_o}, 64'd0);
    mon_en = 1'b1;

    // Clear pass lasts exactly MemWords cycles, then every word reads 0.
    release_and_count("clear_cycles");
    for (int i = 0; i < 16; i++) rd("clr_rd", 32'(i * 4), OK, 32'h0);

    // Byte-enabled writes to word 2.
    wr("wr_full",  32'h8, 4'b1111, 32'hDEADBEEF, OK);
    wr("wr_byte0", 32'h8, 4'b0001, 32'h000000AA, OK);
    rd("rd_merge", 32'h8, OK, 32'hDEADBEAA);
    wr("wr_be0",   32'h8, 4'b0000, 32'hFFFFFFFF, OK);
    rd("rd_be0",   32'h8, OK, 32'hDEADBEAA);
    wr("wr_byte2", 32'hA, 4'b0100, 32'h00550000, OK);
    rd("rd_byte2", 32'h8, OK, 32'hDE55BEAA);

    // Read-after-write on consecutive accept edges.
    @(posedge clk_i); #1;
    write_i = 1'b1; addr_i = 32'hC; be_i = 4'hF; wdata_i = 32'h12345678;
    @(negedge clk_i);
    check_eq("raw_wr_rdy", {63'b0, busy_o}, 64'd0);
    @(posedge clk_i); #1;
    a0 = cyc;
    write_i = 1'b0; read_i = 1'b1;
    @(negedge clk_i);
    check_eq("raw_rd_rdy", {63'b0, busy_o}, 64'd0);
    @(posedge clk_i); #1;
    a1 = cyc;
    read_i = 1'b0;
    expect_resp("raw_wr", 1'b1, OK, 32'h0, a0 + RL - 1);
    expect_resp("raw_rd", 1'b0, OK, 32'h12345678, a1 + RL - 1);

    // Fill words for the throughput run.
    wr("fill0", 32'h00, 4'hF, 32'hA0A0A0A0, OK);
    wr("fill1", 32'h04, 4'hF, 32'h11111111, OK);
    wr("fill4", 32'h10, 4'hF, 32'h44444444, OK);
    wr("fill5", 32'h14, 4'hF, 32'h55555555, OK);
    tp_exp[0] = 32'hA0A0A0A0; tp_exp[1] = 32'h11111111; tp_exp[2] = 32'hDE55BEAA;
    tp_exp[3] = 32'h12345678; tp_exp[4] = 32'h44444444; tp_exp[5] = 32'h55555555;
    repeat (3) @(negedge clk_i);
    check_eq("tp_drained", 64'(rq.size()), 64'd0);

    // Reads held every cycle: busy_o must cap outstanding at 2.
    @(posedge clk_i); #1;
    read_i = 1'b1; addr_i = 32'h0;
    k = 0; edges = 0; mout = 0;
    while (k < 6 && edges < 40) begin
      @(negedge clk_i);
      check_eq("tp_busy", {63'b0, busy_o}, {63'b0, mout == 2});
      acc_b = !busy_o;
      st_b  = rvalid_o | wrespvalid_o;
      @(posedge clk_i); #1;
      edges++;
      if (acc_b) begin
        acyc[k] = cyc;
        k++;
        addr_i = 32'(k * 4);
        if (k == 6) read_i = 1'b0;
      end
      mout = mout + int'(acc_b) - int'(st_b);
    end
    check_eq("tp_edges", 64'(edges), 64'd8);
    for (int i = 0; i < 6; i++) expect_resp("tp_rd", 1'b0, OK, tp_exp[i], acyc[i] + RL - 1);

    // Out of range: decode error, no RAM side effect (0x40 must not alias word 0).
    rd("oor_rd", 32'h40, DEC, 32'h0);
    wr("oor_wr", 32'h40, 4'hF, 32'hFFFFFFFF, DEC);
    rd("oor_top", 32'hFFFFFFFC, DEC, 32'h0);
    rd("oor_chk", 32'h0, OK, 32'hA0A0A0A0);

    // read_i and write_i together: one SLVERR write response, RAM untouched.
    do_req(1'b1, 1'b1, 32'h0, 4'hF, 32'hFFFFFFFF, a0);
    expect_resp("both", 1'b1, SLV, 32'h0, a0 + RL - 1);
    repeat (4) @(negedge clk_i);
    check_eq("both_single", 64'(rq.size()), 64'd0);
    rd("both_chk", 32'h0, OK, 32'hA0A0A0A0);

    // Reset with two reads in flight.
    repeat (3) @(negedge clk_i);
    @(posedge clk_i); #1;
    read_i = 1'b1; addr_i = 32'h8;
    @(negedge clk_i);
    check_eq("inflt_rdy0", {63'b0, busy_o}, 64'd0);
    @(posedge clk_i); #1;
    addr_i = 32'hC;
    @(negedge clk_i);
    check_eq("inflt_rdy1", {63'b0, busy_o}, 64'd0);
    @(posedge clk_i); #1;
    read_i = 1'b0;
    rst_ni = 1'b0;
    repeat (4) @(negedge clk_i);
    check_eq("inflt_busy",  {63'b0, busy_o}, 64'd1);
    check_eq("inflt_drop",  64'(rq.size()), 64'd0);
    check_eq("inflt_resp",  {62'b0, resp_o}, 64'd0);
    release_and_count("reclear_cycles");
    check_eq("reclear_drop", 64'(rq.size()), 64'd0);
    rd("reclear_w2", 32'h8, OK, 32'h0);
    rd("reclear_w0", 32'h0, OK, 32'h0);

    repeat (3) @(negedge clk_i);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
